pwm_dac_stage: RTL and testbench
================================

// Module: pwm_dac_stage
// PURPOSE
//   Output stage downstream of the waveform generator. Accepts its 8-bit sample
//   stream through a valid/ready handshake and converts each sample to a 1-bit
//   density-modulated signal for an external RC filter/DAC pin.
//   Two modes: fixed-period PWM, or first-order sigma-delta. Both hold the sample
//   for one 2^WIDTH-cycle frame.
// PARAMETERS
//   WIDTH      8   sample width; frame length = 2^WIDTH clk cycles
// PORTS
//   clk           in   1      system clock
//   reset         in   1      synchronous, active-high reset
//   enable        in   1      1 = run frames; 0 = hold idle
//   mode          in   1      0 = PWM, 1 = sigma-delta; sampled at frame boundary
//   sample_in     in   WIDTH  unsigned sample from waveform generator
//   sample_valid  in   1      sample_in valid this cycle
//   sample_ready  out  1      stage can accept sample_in this cycle
//   pwm_out       out  1      modulated output bit
//   frame_start   out  1      high during slot 0 of every running frame
// BEHAVIOUR
//   State: slot counter s (WIDTH b), duty reg D, pending reg P + flag p_full,
//     active mode reg M, SD accumulator acc (WIDTH+1 b), FSM {IDLE, RUN}.
//   Reset: s=0, D=0, P=0, p_full=0, M=0, acc=0, FSM=IDLE.
//     Outputs: pwm_out=0, frame_start=0, sample_ready=1.
//   Handshake: transfer when sample_valid && sample_ready.
//     - Transfer writes P and sets p_full.
//     - sample_ready = !p_full || (RUN && s==2^WIDTH-1). Combinational from
//       registers only; it never depends on sample_valid.
//     - In IDLE, transfers are still accepted into P.
//   IDLE: s=0, acc=0, pwm_out=0, frame_start=0. Go to RUN when enable=1.
//     The cycle after the transition is slot 0.
//   RUN:
//     - s increments each cycle and wraps 2^WIDTH-1 -> 0.
//     - frame_start=1 exactly when s==0.
//     - enable=0 goes to IDLE on the next edge (mid-frame abort).
//       D and P are kept; s and acc are cleared.
//   Frame boundary (edge ending slot 2^WIDTH-1, or IDLE->RUN edge):
//     - If p_full, or a transfer happens this cycle: D <= P (bypass if a transfer
//       occurs this same cycle) and p_full <= 0.
//     - Otherwise D is unchanged; the last sample repeats.
//     - M <= mode.
//     - acc <= 0.
//   PWM (M=0): pwm_out=1 in slot s iff s < D.
//     D=0 -> never high; D=2^WIDTH-1 -> high for slots 0..2^WIDTH-2.
//   Sigma-delta (M=1): each slot, acc <= acc[WIDTH-1:0] + D; pwm_out = carry of
//     that add, presented in the same slot.
//     Over one frame, exactly D high slots, spread evenly.
//   pwm_out: glitch-free (driven from a flop or from compare of flops).
//     Must be valid in the slot it belongs to.
//   Width: all arithmetic unsigned; no saturation needed.
//   Reset mid-frame: next cycle all state equals reset values; pwm_out=0 at once.
//   mode changes mid-frame: ignored until the next boundary.
// TESTING
//   1. Reset, enable=1, send 0x40 before first boundary, mode=0 -> frame 1:
//      frame_start pulses once per 256 cycles; pwm_out high slots 0..63 only.
//   2. Duty extremes: send 0x00 then 0xFF in consecutive frames -> 0 high slots,
//      then 255 high slots (slot 255 low).
//   3. Backpressure: 3 back-to-back valid samples 0x10, 0x20, 0x30 mid-frame ->
//      0x10 accepted, ready low until slot 255.
//      0x20 is accepted in slot 255 and bypasses into D (D=0x20 next frame).
//      0x30 is accepted in slot 0.
//   4. mode=1, D=0x80 -> pwm_out alternates 0,1,0,1... across frame.
//      Count = 128 high.
//      D=0x01 -> exactly one high slot (slot 255).
//   5. No new sample for 3 frames after 0x40 -> every frame repeats 64 high slots.
//   6. enable=0 at slot 100, then reset pulse mid-frame -> pwm_out=0, frame_start=0
//      next cycle. After reset: ready=1, D=0.

Source files
------------

// File: rtl/pwm_dac_stage_if.sv
// Sample stream handshake between the waveform generator (master) and the
// PWM/sigma-delta output stage (slave).
interface pwm_dac_stage_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/pwm_dac_stage.sv
// PWM / first-order sigma-delta output stage.
// Each accepted sample is held as the duty value for one 2^WIDTH-slot frame.
// A one-deep pending register decouples the producer from frame timing.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | output held low, slot counter and accumulator cleared
//   ST_RUN  | frames running, slot counter advancing every cycle
module pwm_dac_stage #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_i,
  input  logic            mode_i,
  pwm_dac_stage_if.slave  smp,
  output logic            pwm_out_o,
  output logic            frame_start_o
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [WIDTH-1:0] SLOT_LAST = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             p_full_q, p_full_d;
  logic             m_q, m_d;
  // Only the low WIDTH bits of the accumulator carry over between slots;
  // the carry is regenerated every slot from acc_sum.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   acc_sum;

  logic running;
  logic last_slot;
  logic ready;
  logic xfer;
  logic boundary;

  assign smp.sample_ready = ready;

  // Next-state, handshake and output decode
  always_comb begin
    running   = (state_q == ST_RUN);
    last_slot = running && (s_q == SLOT_LAST);
    ready     = !p_full_q || last_slot;
    xfer      = smp.sample_valid && ready;
    // A frame also ends on the last slot when enable has just dropped, so a
    // sample accepted in that slot lands in D instead of being lost.
    boundary  = last_slot || (!running && enable_i);
    acc_sum   = {1'b0, acc_q} + {1'b0, d_q};

    state_d  = state_q;
    s_d      = s_q;
    d_d      = d_q;
    p_d      = p_q;
    p_full_d = p_full_q;
    m_d      = m_q;
    acc_d    = acc_q;

    if (xfer) begin
      p_d      = smp.sample_in;
      p_full_d = 1'b1;
    end

    if (boundary) begin
      if (xfer) begin
        d_d = smp.sample_in;
      end else if (p_full_q) begin
        d_d = p_q;
      end
      p_full_d = 1'b0;
      m_d      = mode_i;
    end

    case (state_q)
      ST_IDLE: begin
        s_d   = '0;
        acc_d = '0;
        if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
          s_d     = '0;
          acc_d   = '0;
        end else begin
          s_d   = s_q + 1'b1;
          acc_d = last_slot ? '0 : acc_sum[WIDTH-1:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    frame_start_o = running && (s_q == '0);
    pwm_out_o     = running && (m_q ? acc_sum[WIDTH] : (s_q < d_q));
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      p_full_q <= 1'b0;
      m_q      <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      d_q      <= d_d;
      p_q      <= p_d;
      p_full_q <= p_full_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_pwm_dac_stage.sv
// Self-checking bench for pwm_dac_stage: frame-level reference model feeding
// a queue of expected frames, and a negedge monitor that checks every slot.
module tb_pwm_dac_stage;

  localparam int W     = 8;
  localparam int SLOTS = 1 << W;

  typedef struct {
    int duty;
    bit mode;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic mode;
  logic pwm_out;
  logic frame_start;

  pwm_dac_stage_if #(.WIDTH(W)) ifc ();

  pwm_dac_stage #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable),
    .mode_i        (mode),
    .smp           (ifc),
    .pwm_out_o     (pwm_out),
    .frame_start_o (frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit     m_run   = 1'b0;
  int     m_slot  = 0;
  int     m_duty  = 0;
  int     m_pend  = 0;
  bit     m_pfull = 1'b0;
  bit     m_xfer  = 1'b0;
  frame_t exp_q[$];

  always @(posedge clk) begin
    bit     rdy, bnd;
    frame_t f;
    if (reset) begin
      m_run = 0; m_slot = 0; m_duty = 0; m_pend = 0; m_pfull = 0; m_xfer = 0;
      exp_q.delete();
    end else begin
      rdy    = !m_pfull || (m_run && m_slot == SLOTS - 1);
      m_xfer = ifc.sample_valid && rdy;
      bnd    = (m_run && m_slot == SLOTS - 1) || (!m_run && enable);
      if (bnd) begin
        if (m_xfer) m_duty = int'(ifc.sample_in);
        else if (m_pfull) m_duty = m_pend;
        m_pfull = 0;
        if (enable) begin
          f.duty = m_duty;
          f.mode = mode;
          exp_q.push_back(f);
        end
      end else if (m_xfer) begin
        m_pend  = int'(ifc.sample_in);
        m_pfull = 1;
      end
      if (!enable) begin
        m_run = 0; m_slot = 0;
      end else if (m_run) begin
        m_slot = (m_slot + 1) % SLOTS;
      end else begin
        m_run = 1; m_slot = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  frame_t cur;
  bit     have = 1'b0;
  int     k    = 0;
  int     hi   = 0;

  always @(negedge clk) begin
    int exp_pwm;
    chk("sample_ready", int'(ifc.sample_ready),
        int'(!m_pfull || (m_run && m_slot == SLOTS - 1)));
    chk("frame_start", int'(frame_start), int'(m_run && m_slot == 0));
    if (frame_start) begin
      k  = 0;
      hi = 0;
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        have = 1;
      end else begin
        have = 0;
        chk("frame_queue_nonempty", 0, 1);
      end
    end else begin
      k++;
    end
    exp_pwm = 0;
    if (m_run && have) begin
      if (cur.mode) exp_pwm = int'(((k + 1) * cur.duty) / SLOTS != (k * cur.duty) / SLOTS);
      else          exp_pwm = int'(k < cur.duty);
    end
    chk("pwm_out", int'(pwm_out), exp_pwm);
    hi += int'(pwm_out);
    if (m_run && have && k == SLOTS - 1) chk("frame_high_count", hi, cur.duty);
    if (!m_run) have = 0;
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    int n = 0;
    ifc.sample_in    = W'(d);
    ifc.sample_valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_xfer && n < 2000);
    if (!m_xfer) chk("send_accept_timeout", 0, 1);
    ifc.sample_valid = 1'b0;
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(m_run && m_slot == s) && n < 2000);
    if (!(m_run && m_slot == s)) chk("wait_slot_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0;
    ifc.sample_in = '0; ifc.sample_valid = 1'b0;
    cycles(3);
    reset = 1'b0;

    // 0x40 PWM frames
    enable = 1'b1;
    send(8'h40);
    cycles(2 * SLOTS);

    // Duty extremes
    send(8'h00);
    cycles(SLOTS + 10);
    send(8'hFF);
    cycles(2 * SLOTS);

    // Backpressure: 0x10 pending, 0x20 bypasses at slot 255, 0x30 in slot 0
    wait_slot(50);
    send(8'h10);
    send(8'h20);
    send(8'h30);
    cycles(2 * SLOTS);

    // Sigma-delta
    mode = 1'b1;
    send(8'h80);
    cycles(2 * SLOTS);
    send(8'h01);
    cycles(2 * SLOTS);

    // Repeat of last sample over several frames
    mode = 1'b0;
    send(8'h40);
    cycles(4 * SLOTS);

    // Mid-frame abort, restart, then mid-frame reset
    wait_slot(100);
    enable = 1'b0;
    cycles(5);
    enable = 1'b1;
    cycles(70);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(SLOTS + 20);

    // Randomized traffic with mode changes and occasional aborts
    for (int i = 0; i < 20; i++) begin
      mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        cycles($urandom_range(1, 20));
        enable = 1'b1;
      end
      send($urandom_range(0, 255));
      cycles($urandom_range(0, 400));
    end
    cycles(SLOTS + 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
